// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the back-end control pipeline: NOP word, control-word
// field layout and stage index names.
package ctrl_pipe_pkg;

  typedef struct packed {
    logic [2:0] spare;
    logic       bl;
    logic       b;
    logic       size;
    logic       ldst;
    logic       rf_en;
    logic       load;
    logic       s_bit;
    logic [1:0] shift_am;
    logic [3:0] alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  typedef enum int {
    STG_EX  = 0,
    STG_MEM = 1,
    STG_WB  = 2
  } stage_idx_e;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Upstream-facing bundle of the control pipeline: ID-side inputs, hazard
// controls, per-stage outputs and performance counters.
interface ctrl_pipeline_if #(
  parameter int CW     = 16,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
);
  logic                    in_valid;
  logic [CW-1:0]           in_ctrl;
  logic                    nop_sel;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic                    in_ready;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*CW-1:0]    stage_ctrl;
  logic [CNT_W-1:0]        bubble_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport master (
    output in_valid, in_ctrl, nop_sel, stall, flush,
    input  in_ready, stage_valid, stage_ctrl, bubble_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, nop_sel, stall, flush,
    output in_ready, stage_valid, stage_ctrl, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// One valid+control register slice. Bubble beats hold, hold beats load.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_i,
  input  logic          bubble_i,
  input  logic          vld_i,
  input  logic [CW-1:0] ctrl_i,
  output logic          vld_o,
  output logic [CW-1:0] ctrl_o
);
  localparam logic [CW-1:0] NOP_W = CW'(CTRL_NOP);

  logic          vld_q, vld_d;
  logic [CW-1:0] ctrl_q, ctrl_d;

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    if (bubble_i) begin
      vld_d  = 1'b0;
      ctrl_d = NOP_W;
    end else if (!hold_i) begin
      vld_d  = vld_i;
      ctrl_d = ctrl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= NOP_W;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign vld_o  = vld_q;
  assign ctrl_o = ctrl_q;
endmodule

// File: rtl/ctrl_pipeline.sv
// Parametrised control-word pipeline (ID -> STAGES back-end stages) with stall,
// flush and NOP insertion. Define CTRL_PIPE_PERF_EN to build the bubble/flush counters.
module ctrl_pipeline
  import ctrl_pipe_pkg::*;
#(
  parameter int CW     = 16,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input logic            Clk,
  input logic            Reset,
  ctrl_pipeline_if.slave bus
);
  localparam logic [CW-1:0] NOP_W = CW'(CTRL_NOP);

  logic [STAGES-1:0] h;
  logic [STAGES-1:0] bub;
  logic [STAGES-1:0] ld_vld;
  logic [STAGES-1:0] vld_q;
  logic [CW-1:0]     ld_ctrl [STAGES];
  logic [CW-1:0]     ctrl_q  [STAGES];

  // A stall in any later stage backs up every earlier one.
  always_comb begin
    h[STAGES-1] = bus.stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      h[i] = h[i+1] | bus.stall[i];
    end
  end

  assign bus.in_ready    = ~h[0];
  assign bus.stage_valid = vld_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_stg
    if (g == 0) begin : g_first
      assign ld_vld[g]  = bus.in_valid & ~bus.nop_sel;
      assign ld_ctrl[g] = ld_vld[g] ? bus.in_ctrl : NOP_W;
      assign bub[g]     = bus.flush[g];
    end else begin : g_rest
      assign ld_vld[g]  = vld_q[g-1];
      assign ld_ctrl[g] = ctrl_q[g-1];
      // Flush beats hold; a held or killed predecessor leaves a bubble behind.
      assign bub[g]     = bus.flush[g] | (~h[g] & (h[g-1] | bus.flush[g-1]));
    end

    ctrl_pipe_stage #(.CW(CW)) u_stage (
      .clk      (Clk),
      .rst      (Reset),
      .hold_i   (h[g]),
      .bubble_i (bub[g]),
      .vld_i    (ld_vld[g]),
      .ctrl_i   (ld_ctrl[g]),
      .vld_o    (vld_q[g]),
      .ctrl_o   (ctrl_q[g])
    );

    assign bus.stage_ctrl[g*CW +: CW] = ctrl_q[g];
  end

`ifdef CTRL_PIPE_PERF_EN
  logic             last_vld_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  // Mirror of the last stage's next-state valid, so the count reflects the post-edge state.
  assign last_vld_d = ~bub[STAGES-1] &
                      (h[STAGES-1] ? vld_q[STAGES-1] : ld_vld[STAGES-1]);

  always_comb begin
    bubble_cnt_d = sat_inc(bubble_cnt_q, ~last_vld_d);
    flush_cnt_d  = sat_inc(flush_cnt_q, |(bus.flush & vld_q));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
`else
  assign bus.bubble_cnt = '0;
  assign bus.flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: the driver queues hand-computed post-edge state,
// the monitor compares it after each rising edge.
module tb_ctrl_pipeline;
  localparam int CW    = 16;
  localparam int ST    = 3;
  localparam int CNT_W = 4;
`ifdef CTRL_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  ctrl_pipeline_if #(.CW(CW), .STAGES(ST), .CNT_W(CNT_W)) bus ();

  ctrl_pipeline #(.CW(CW), .STAGES(ST), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       nm;
    bit          chk;
    logic [2:0]  vld;
    logic [47:0] ctrl;
    logic        rdy;
    logic [3:0]  bub;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [3:0] pc(input int v);
    return PERF ? 4'(v) : 4'd0;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic step(input bit r, input bit iv, input logic [15:0] c, input bit nop,
                      input logic [2:0] st, input logic [2:0] fl, input string nm,
                      input bit chk, input logic [2:0] ev, input logic [47:0] ec,
                      input int eb, input int ef);
    exp_t e;
    @(negedge Clk);
    Reset        = r;
    bus.in_valid = iv;
    bus.in_ctrl  = c;
    bus.nop_sel  = nop;
    bus.stall    = st;
    bus.flush    = fl;
    e.nm   = nm;
    e.chk  = chk;
    e.vld  = ev;
    e.ctrl = ec;
    e.rdy  = ~|st;
    e.bub  = pc(eb);
    e.fl   = pc(ef);
    sb.push_back(e);
    @(posedge Clk);
  endtask

  // Monitor: outputs are a registered snapshot, so one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check({e.nm, ".valid"},  64'(bus.stage_valid), 64'(e.vld));
          check({e.nm, ".ctrl"},   64'(bus.stage_ctrl),  64'(e.ctrl));
          check({e.nm, ".ready"},  64'(bus.in_ready),    64'(e.rdy));
          check({e.nm, ".bubble"}, 64'(bus.bubble_cnt),  64'(e.bub));
          check({e.nm, ".flush"},  64'(bus.flush_cnt),   64'(e.fl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_ctrl  = '0;
    bus.nop_sel  = 1'b0;
    bus.stall    = '0;
    bus.flush    = '0;

    // Reset state
    step(1, 0, 16'h0, 0, 3'b000, 3'b000, "reset", 1, 3'b000, 48'h0, 0, 0);
    // Streaming
    step(0, 1, 16'h0101, 0, 3'b000, 3'b000, "strA", 1, 3'b001, {16'h0, 16'h0, 16'h0101}, 1, 0);
    step(0, 1, 16'h0102, 0, 3'b000, 3'b000, "strB", 1, 3'b011, {16'h0, 16'h0101, 16'h0102}, 2, 0);
    step(0, 1, 16'h0103, 0, 3'b000, 3'b000, "strC", 1, 3'b111, {16'h0101, 16'h0102, 16'h0103}, 2, 0);
    // NOP insertion
    step(0, 1, 16'h01FF, 1, 3'b000, 3'b000, "nop", 1, 3'b110, {16'h0102, 16'h0103, 16'h0}, 2, 0);
    step(0, 0, 16'h0, 0, 3'b000, 3'b000, "drain1", 1, 3'b100, {16'h0103, 16'h0, 16'h0}, 2, 0);
    step(0, 0, 16'h0, 0, 3'b000, 3'b000, "drain2", 1, 3'b000, 48'h0, 3, 0);

    // Mid-stage stall
    step(1, 0, 16'h0, 0, 3'b000, 3'b000, "rst4", 1, 3'b000, 48'h0, 0, 0);
    step(0, 1, 16'h0B0B, 0, 3'b000, 3'b000, "ldB", 1, 3'b001, {16'h0, 16'h0, 16'h0B0B}, 1, 0);
    step(0, 1, 16'h0A0A, 0, 3'b000, 3'b000, "ldA", 1, 3'b011, {16'h0, 16'h0B0B, 16'h0A0A}, 2, 0);
    step(0, 1, 16'h0C0C, 0, 3'b010, 3'b000, "stall1", 1, 3'b011, {16'h0, 16'h0B0B, 16'h0A0A}, 3, 0);
    step(0, 1, 16'h0C0C, 0, 3'b010, 3'b000, "stall2", 1, 3'b011, {16'h0, 16'h0B0B, 16'h0A0A}, 4, 0);
    step(0, 1, 16'h0C0C, 0, 3'b000, 3'b000, "unstall", 1, 3'b111, {16'h0B0B, 16'h0A0A, 16'h0C0C}, 4, 0);

    // Flush beats stall, killed entries do not propagate
    step(1, 0, 16'h0, 0, 3'b000, 3'b000, "rst5", 1, 3'b000, 48'h0, 0, 0);
    step(0, 1, 16'h0C0C, 0, 3'b000, 3'b000, "ldC", 1, 3'b001, {16'h0, 16'h0, 16'h0C0C}, 1, 0);
    step(0, 1, 16'h0B0B, 0, 3'b000, 3'b000, "ldB2", 1, 3'b011, {16'h0, 16'h0C0C, 16'h0B0B}, 2, 0);
    step(0, 1, 16'h0A0A, 0, 3'b000, 3'b000, "ldA2", 1, 3'b111, {16'h0C0C, 16'h0B0B, 16'h0A0A}, 2, 0);
    step(0, 1, 16'h0D0D, 0, 3'b001, 3'b011, "flush", 1, 3'b000, 48'h0, 3, 1);
    step(0, 0, 16'h0, 0, 3'b000, 3'b000, "postfl", 1, 3'b000, 48'h0, 4, 1);

    // Last-stage stall, flush+stall on WB, reset while stalled
    step(1, 0, 16'h0, 0, 3'b000, 3'b000, "rst7", 1, 3'b000, 48'h0, 0, 0);
    step(0, 1, 16'h0111, 0, 3'b000, 3'b000, "ldX", 1, 3'b001, {16'h0, 16'h0, 16'h0111}, 1, 0);
    step(0, 1, 16'h0122, 0, 3'b000, 3'b000, "ldY", 1, 3'b011, {16'h0, 16'h0111, 16'h0122}, 2, 0);
    step(0, 1, 16'h0133, 0, 3'b000, 3'b000, "ldZ", 1, 3'b111, {16'h0111, 16'h0122, 16'h0133}, 2, 0);
    step(0, 1, 16'h0144, 0, 3'b100, 3'b000, "wbstall", 1, 3'b111, {16'h0111, 16'h0122, 16'h0133}, 2, 0);
    step(0, 1, 16'h0144, 0, 3'b100, 3'b100, "wbflst", 1, 3'b011, {16'h0, 16'h0122, 16'h0133}, 3, 1);
    step(0, 0, 16'h0, 0, 3'b000, 3'b000, "wbrel", 1, 3'b110, {16'h0122, 16'h0133, 16'h0}, 3, 1);
    step(1, 1, 16'h0155, 0, 3'b100, 3'b000, "rststall", 1, 3'b000, 48'h0, 0, 0);

    // Idle saturation of the bubble counter
    step(1, 0, 16'h0, 0, 3'b000, 3'b000, "rst6", 1, 3'b000, 48'h0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 16'h0, 0, 3'b000, 3'b000, $sformatf("idle%0d", i), 1, 3'b000, 48'h0,
           (i > 15) ? 15 : i, 0);
    end

    repeat (4) @(posedge Clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
